// File: rtl/pdp8_iot_master.sv
// pdp8_iot_master
// CPU-side initiator of the PDP-8 IOT bus. Takes one IOT instruction and the
// current AC from the CPU sequencer, then walks the bus through the major
// states F0..F3 (STATE_CYCLES clocks each). It samples the peripheral's data
// and skip on the last F3 clock and returns the new AC and skip flag with a
// one-clock done pulse. Device 00 (SKON/ION/IOF) is executed locally with no
// bus cycle. The peripheral interrupt line is qualified into int_req.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_inst, req_ac      IOT instruction word and AC at request time
//   done                  one-clock pulse, rsp_ac/rsp_skip valid (held after)
//   rsp_ac, rsp_skip      resulting AC and skip flag
//   iot, state            bus cycle active / major state (F0..F3, idle=1111)
//   mb, io_select         instruction word and device code for the bus
//   io_data_out           AC presented to the peripheral
//   io_data_in/avail      data returned by the peripheral
//   io_skip               peripheral skip
//   io_interrupt          OR of peripheral interrupt requests
//   int_req, int_enable   qualified interrupt request / ION flip-flop
module pdp8_iot_master #(
  parameter int STATE_CYCLES = 1,
  parameter int SYNC_INT     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_inst,
  input  logic [11:0] req_ac,
  output logic        done,
  output logic [11:0] rsp_ac,
  output logic        rsp_skip,
  output logic        iot,
  output logic [3:0]  state,
  output logic [11:0] mb,
  output logic [5:0]  io_select,
  output logic [11:0] io_data_out,
  input  logic [11:0] io_data_in,
  input  logic        io_data_avail,
  input  logic        io_skip,
  input  logic        io_interrupt,
  output logic        int_req,
  output logic        int_enable
);

  localparam logic [3:0]  CNT_LAST  = 4'(STATE_CYCLES - 1);
  localparam logic [11:0] INST_SKON = 12'o6000;
  localparam logic [11:0] INST_ION  = 12'o6001;
  localparam logic [11:0] INST_IOF  = 12'o6002;

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DONE
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] mb_q, mb_d;
  logic [11:0] dout_q, dout_d;
  logic [11:0] ac_hold_q, ac_hold_d;
  logic [11:0] rsp_ac_q, rsp_ac_d;
  logic        rsp_skip_q, rsp_skip_d;
  logic        ie_q, ie_d;
  logic        ion_delay_q, ion_delay_d;
  logic        bus_active, cnt_last, int_sync;
  logic [2:0]  fl_int, fl_bus;

  // Interrupt-flag effects of one completed instruction, as {skip, ie, delay}.
  // Any instruction other than ION/IOF/SKON completes a pending ION delay.
  function automatic logic [2:0] flag_update(input logic [11:0] inst,
                                             input logic        internal,
                                             input logic        ie,
                                             input logic        dly);
    logic [2:0] r;
    r = dly ? 3'b010 : {1'b0, ie, 1'b0};
    if (internal) begin
      if (inst == INST_ION)       r = {1'b0, ie, 1'b1};
      else if (inst == INST_IOF)  r = 3'b000;
      else if (inst == INST_SKON) r = {ie, 2'b00};
    end
    return r;
  endfunction

  assign bus_active = (fsm_q == S_F0) || (fsm_q == S_F1) ||
                      (fsm_q == S_F2) || (fsm_q == S_F3);
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign cnt_d      = (bus_active && !cnt_last) ? cnt_q + 4'd1 : 4'd0;
  assign fl_int     = flag_update(req_inst, 1'b1, ie_q, ion_delay_q);
  assign fl_bus     = flag_update(mb_q, 1'b0, ie_q, ion_delay_q);

  // Results and flag updates are registered on the edge entering DONE, so
  // they are already visible while done is high.
  always_comb begin
    fsm_d       = fsm_q;
    mb_d        = mb_q;
    dout_d      = dout_q;
    ac_hold_d   = ac_hold_q;
    rsp_ac_d    = rsp_ac_q;
    rsp_skip_d  = rsp_skip_q;
    ie_d        = ie_q;
    ion_delay_d = ion_delay_q;
    case (fsm_q)
      S_IDLE: begin
        if (req_valid) begin
          mb_d      = req_inst;
          dout_d    = req_ac;
          ac_hold_d = req_ac;
          if (req_inst[8:3] == 6'd0) begin
            fsm_d       = S_DONE;
            rsp_ac_d    = req_ac;
            rsp_skip_d  = fl_int[2];
            ie_d        = fl_int[1];
            ion_delay_d = fl_int[0];
          end else begin
            fsm_d = S_F0;
          end
        end
      end
      S_F0: if (cnt_last) fsm_d = S_F1;
      S_F1: if (cnt_last) fsm_d = S_F2;
      S_F2: if (cnt_last) fsm_d = S_F3;
      S_F3: begin
        // Only the last F3 clock samples the peripheral.
        if (cnt_last) begin
          fsm_d       = S_DONE;
          ac_hold_d   = io_data_avail ? io_data_in : ac_hold_q;
          rsp_ac_d    = io_data_avail ? io_data_in : ac_hold_q;
          rsp_skip_d  = io_skip;
          ie_d        = fl_bus[1];
          ion_delay_d = fl_bus[0];
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= 4'd0;
      mb_q        <= 12'd0;
      dout_q      <= 12'd0;
      ac_hold_q   <= 12'd0;
      rsp_ac_q    <= 12'd0;
      rsp_skip_q  <= 1'b0;
      ie_q        <= 1'b0;
      ion_delay_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      mb_q        <= mb_d;
      dout_q      <= dout_d;
      ac_hold_q   <= ac_hold_d;
      rsp_ac_q    <= rsp_ac_d;
      rsp_skip_q  <= rsp_skip_d;
      ie_q        <= ie_d;
      ion_delay_q <= ion_delay_d;
    end
  end

  generate
    if (SYNC_INT != 0) begin : g_sync
      logic [1:0] sync_q, sync_d;
      assign sync_d = {sync_q[0], io_interrupt};
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= sync_d;
      end
      assign int_sync = sync_q[1];
    end else begin : g_nosync
      assign int_sync = io_interrupt;
    end
  endgenerate

  always_comb begin
    state = 4'b1111;
    case (fsm_q)
      S_F0:    state = 4'b0000;
      S_F1:    state = 4'b0001;
      S_F2:    state = 4'b0010;
      S_F3:    state = 4'b0011;
      default: state = 4'b1111;
    endcase
  end

  assign req_ready   = (fsm_q == S_IDLE);
  assign done        = (fsm_q == S_DONE);
  assign iot         = bus_active;
  assign mb          = mb_q;
  assign io_select   = mb_q[8:3];
  assign io_data_out = dout_q;
  assign rsp_ac      = rsp_ac_q;
  assign rsp_skip    = rsp_skip_q;
  assign int_enable  = ie_q;
  assign int_req     = ie_q & int_sync;

endmodule

// File: tb/tb_pdp8_iot_master.sv
// Testbench for pdp8_iot_master: two instances (STATE_CYCLES=1 and 3) with a
// scoreboard of expected responses checked whenever done pulses.
module tb_pdp8_iot_master;

  localparam int SC0 = 1;
  localparam int SC1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [11:0] req_inst [2];
  logic [11:0] req_ac [2];
  logic        done [2];
  logic [11:0] rsp_ac [2];
  logic        rsp_skip [2];
  logic        iot [2];
  logic [3:0]  state [2];
  logic [11:0] mb [2];
  logic [5:0]  io_select [2];
  logic [11:0] io_data_out [2];
  logic [11:0] io_data_in [2];
  logic        io_data_avail [2];
  logic        io_skip [2];
  logic        io_interrupt [2];
  logic        int_req [2];
  logic        int_enable [2];

  pdp8_iot_master #(.STATE_CYCLES(SC0), .SYNC_INT(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_inst(req_inst[0]), .req_ac(req_ac[0]), .done(done[0]), .rsp_ac(rsp_ac[0]),
    .rsp_skip(rsp_skip[0]), .iot(iot[0]), .state(state[0]), .mb(mb[0]),
    .io_select(io_select[0]), .io_data_out(io_data_out[0]), .io_data_in(io_data_in[0]),
    .io_data_avail(io_data_avail[0]), .io_skip(io_skip[0]), .io_interrupt(io_interrupt[0]),
    .int_req(int_req[0]), .int_enable(int_enable[0]));

  pdp8_iot_master #(.STATE_CYCLES(SC1), .SYNC_INT(1)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_inst(req_inst[1]), .req_ac(req_ac[1]), .done(done[1]), .rsp_ac(rsp_ac[1]),
    .rsp_skip(rsp_skip[1]), .iot(iot[1]), .state(state[1]), .mb(mb[1]),
    .io_select(io_select[1]), .io_data_out(io_data_out[1]), .io_data_in(io_data_in[1]),
    .io_data_avail(io_data_avail[1]), .io_skip(io_skip[1]), .io_interrupt(io_interrupt[1]),
    .int_req(int_req[1]), .int_enable(int_enable[1]));

  typedef struct packed {
    logic [11:0] ac;
    logic        skip;
    logic        ie;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  exp_t last_exp [2];
  logic ie_m [2];
  logic dly_m [2];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst%0d) at %0t: got %0o, expected %0o", name, k, $time, act, exp);
    end
  endtask

  function automatic int sc_of(input int k);
    return (k == 0) ? SC0 : SC1;
  endfunction

  // Reference model: one instruction's architectural effect. pdata/pavail/pskip
  // are the peripheral values present on the final F3 clock.
  task automatic model_push(input int k, input logic [11:0] inst, input logic [11:0] ac,
                            input logic [11:0] pdata, input logic pavail, input logic pskip);
    exp_t e;
    e.ac   = ac;
    e.skip = 1'b0;
    if (inst[8:3] != 6'd0) begin
      if (pavail) e.ac = pdata;
      e.skip = pskip;
      if (dly_m[k]) begin ie_m[k] = 1'b1; dly_m[k] = 1'b0; end
    end else if (inst == 12'o6001) begin
      dly_m[k] = 1'b1;
    end else if (inst == 12'o6002) begin
      ie_m[k] = 1'b0; dly_m[k] = 1'b0;
    end else if (inst == 12'o6000) begin
      e.skip = ie_m[k]; ie_m[k] = 1'b0; dly_m[k] = 1'b0;
    end else if (dly_m[k]) begin
      ie_m[k] = 1'b1; dly_m[k] = 1'b0;
    end
    e.ie = ie_m[k];
    last_exp[k] = e;
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  // Monitor: every done pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) begin
        have = 1'b0;
        if (k == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
        if (k == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected (inst%0d) at %0t: done=1, expected no response", k, $time);
        end else begin
          chk("rsp_ac", k, 32'(rsp_ac[k]), 32'(e.ac));
          chk("rsp_skip", k, 32'(rsp_skip[k]), 32'(e.skip));
          chk("int_enable_at_done", k, 32'(int_enable[k]), 32'(e.ie));
        end
      end
    end
  end

  // mode 0: peripheral quiet; 1: random every clock; 2: 7777/avail/skip only in F1;
  // 3: 7777/avail/skip only in F3.
  task automatic drive_periph(input int k, input int j, input int sc, input int mode,
                              input logic [11:0] ld, input logic la, input logic ls);
    io_data_in[k] = 12'($urandom); io_data_avail[k] = 1'b0; io_skip[k] = 1'b0;
    case (mode)
      1: begin
        if (j == 4*sc - 1) begin
          io_data_in[k] = ld; io_data_avail[k] = la; io_skip[k] = ls;
        end else begin
          io_data_avail[k] = 1'($urandom); io_skip[k] = 1'($urandom);
        end
      end
      2: if (j / sc == 1) begin io_data_in[k] = 12'o7777; io_data_avail[k] = 1'b1; io_skip[k] = 1'b1; end
      3: if (j / sc == 3) begin io_data_in[k] = ld; io_data_avail[k] = la; io_skip[k] = ls; end
      default: ;
    endcase
  endtask

  task automatic wait_ready(input int k);
    int t;
    t = 0;
    while (req_ready[k] !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    chk("req_ready_wait", k, 32'(req_ready[k]), 32'd1);
  endtask

  task automatic run_iot(input int k, input logic [11:0] inst, input logic [11:0] ac,
                         input int mode, input logic poke);
    int sc, jdone, n_iot;
    logic [11:0] ld;
    logic la, ls, bus;
    logic [3:0] exp_state;
    sc  = sc_of(k);
    bus = (inst[8:3] != 6'd0);
    ld  = 12'($urandom);
    la  = 1'b0;
    ls  = 1'b0;
    if (mode == 1) begin la = 1'($urandom); ls = 1'($urandom); end
    if (mode == 3) begin ld = 12'o7777; la = 1'b1; ls = 1'b1; end
    wait_ready(k);
    req_valid[k] = 1'b1; req_inst[k] = inst; req_ac[k] = ac;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_inst[k] = 12'($urandom) | 12'o0010; req_ac[k] = 12'($urandom);
    model_push(k, inst, ac, ld, la, ls);
    jdone = bus ? 4*sc : 0;
    n_iot = 0;
    for (int j = 0; j <= jdone; j++) begin
      drive_periph(k, j, sc, mode, ld, la, ls);
      req_valid[k] = poke && bus && (j == sc);
      @(negedge clk);
      if (j == 0) begin
        chk("mb", k, 32'(mb[k]), 32'(inst));
        chk("io_select", k, 32'(io_select[k]), 32'(inst[8:3]));
        chk("io_data_out", k, 32'(io_data_out[k]), 32'(ac));
      end
      exp_state = (bus && j < jdone) ? 4'(j / sc) : 4'b1111;
      chk("done_timing", k, 32'(done[k]), 32'(j == jdone));
      chk("state", k, 32'(state[k]), 32'(exp_state));
      chk("iot", k, 32'(iot[k]), 32'(bus && j < jdone));
      if (iot[k] === 1'b1) n_iot++;
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    drive_periph(k, 0, sc, 0, ld, la, ls);
    chk("iot_cycles", k, 32'(n_iot), bus ? 32'(4*sc) : 32'd0);
    chk("req_ready_after", k, 32'(req_ready[k]), 32'd1);
    chk("rsp_ac_hold", k, 32'(rsp_ac[k]), 32'(last_exp[k].ac));
    chk("rsp_skip_hold", k, 32'(rsp_skip[k]), 32'(last_exp[k].skip));
    chk("int_req", k, 32'(int_req[k]), 32'(ie_m[k] & io_interrupt[k]));
  endtask

  task automatic abort_iot(input int k, input logic [11:0] inst, input logic [11:0] ac);
    wait_ready(k);
    req_valid[k] = 1'b1; req_inst[k] = inst; req_ac[k] = ac;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    repeat (2*sc_of(k)) begin @(posedge clk); #1; end
    chk("abort_in_f2", k, 32'(state[k]), 32'd2);
    reset[k] = 1'b1;
    #1;
    chk("abort_iot", k, 32'(iot[k]), 32'd0);
    chk("abort_state", k, 32'(state[k]), 32'hF);
    chk("abort_done", k, 32'(done[k]), 32'd0);
    chk("abort_ready", k, 32'(req_ready[k]), 32'd1);
    ie_m[k] = 1'b0; dly_m[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] inst;
    logic [5:0]  dev;
    int          k;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_inst[i] = '0; req_ac[i] = '0;
      io_data_in[i] = '0; io_data_avail[i] = 1'b0; io_skip[i] = 1'b0;
      io_interrupt[i] = 1'b0; ie_m[i] = 1'b0; dly_m[i] = 1'b0; last_exp[i] = '0;
    end
    #50;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", i, 32'(req_ready[i]), 32'd1);
      chk("reset_iot", i, 32'(iot[i]), 32'd0);
      chk("reset_state", i, 32'(state[i]), 32'hF);
      chk("reset_int_req", i, 32'(int_req[i]), 32'd0);
      chk("reset_int_enable", i, 32'(int_enable[i]), 32'd0);
      chk("reset_done", i, 32'(done[i]), 32'd0);
      chk("reset_mb", i, 32'(mb[i]), 32'd0);
      chk("reset_rsp_ac", i, 32'(rsp_ac[i]), 32'd0);
    end
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(posedge clk); #1;

    // Directed bus cycles
    run_iot(0, 12'o6603, 12'o1234, 0, 1'b0);
    run_iot(0, 12'o6611, 12'o0055, 3, 1'b0);
    run_iot(0, 12'o6611, 12'o0123, 2, 1'b0);
    run_iot(1, 12'o6605, 12'o4321, 0, 1'b0);
    run_iot(1, 12'o6611, 12'o0001, 3, 1'b0);

    // ION delay and interrupt qualification
    run_iot(0, 12'o6001, 12'o0777, 0, 1'b0);
    chk("ion_delay_ie", 0, 32'(int_enable[0]), 32'd0);
    run_iot(0, 12'o6603, 12'o0100, 0, 1'b0);
    chk("ion_enabled", 0, 32'(int_enable[0]), 32'd1);
    @(posedge clk); #1;
    io_interrupt[0] = 1'b1;
    @(negedge clk); chk("int_lat0", 0, 32'(int_req[0]), 32'd0);
    @(posedge clk); @(negedge clk); chk("int_lat1", 0, 32'(int_req[0]), 32'd0);
    @(posedge clk); @(negedge clk); chk("int_lat2", 0, 32'(int_req[0]), 32'd1);
    @(posedge clk); #1;
    run_iot(0, 12'o6002, 12'o0200, 0, 1'b0);
    chk("iof_int_req", 0, 32'(int_req[0]), 32'd0);
    run_iot(0, 12'o6001, 12'o0200, 0, 1'b0);
    run_iot(0, 12'o6000, 12'o0300, 0, 1'b0);

    // Busy requests are ignored
    run_iot(0, 12'o6603, 12'o2222, 1, 1'b1);
    run_iot(1, 12'o6605, 12'o3333, 1, 1'b1);

    // Reset in F2 aborts without a done
    abort_iot(0, 12'o6603, 12'o0707);
    abort_iot(1, 12'o6605, 12'o0707);
    run_iot(0, 12'o6641, 12'o0011, 1, 1'b0);
    run_iot(1, 12'o6641, 12'o0011, 1, 1'b0);

    // Randomized instruction stream
    io_interrupt[1] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      k   = i % 2;
      dev = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      inst = {3'o6, dev, 3'($urandom)};
      run_iot(k, inst, 12'($urandom), 1, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 0, 32'(sbq0.size()), 32'd0);
    chk("sb_empty", 1, 32'(sbq1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp8_iot_master.md
Name: pdp8_iot_master

Overview:
- CPU-side initiator of the PDP-8 IOT bus; the opposite end of the interface that peripheral controllers (pdp8_rf and siblings) respond on.
- Accepts one IOT instruction plus the current AC from the CPU sequencer and steps the bus through major states F0..F3 while driving iot/mb/io_select/io_data_out.
- Samples the peripheral's returned data and skip, and hands the updated AC and skip flag back to the CPU.
- Handles processor-internal device 00 (ION/IOF/SKON) locally and qualifies the peripheral interrupt line into int_req.

Parameters:
- STATE_CYCLES, 1, clocks spent in each major state F0..F3 (1..15).
- SYNC_INT, 1, 1 = double-register io_interrupt before use; 0 = use directly.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  CPU requests an IOT; sampled when req_ready=1
- req_ready  output  1  high in IDLE only
- req_inst  input  12  IOT instruction word (6xxx octal)
- req_ac  input  12  AC value at request time
- done  output  1  one-clock pulse: rsp_ac/rsp_skip valid
- rsp_ac  output  12  resulting AC
- rsp_skip  output  1  instruction skipped (PC+1 required)
- iot  output  1  high while a bus IOT is in progress (F0..F3)
- state  output  4  major state: F0=0000, F1=0001, F2=0010, F3=0011, idle=1111
- mb  output  12  instruction word, held for the whole bus cycle
- io_select  output  6  device code = mb[8:3]
- io_data_out  output  12  AC presented to peripheral
- io_data_in  input  12  data returned by peripheral
- io_data_avail  input  1  io_data_in valid; qualified in F3
- io_skip  input  1  peripheral skip; qualified in F3
- io_interrupt  input  1  OR of peripheral interrupt requests
- int_req  output  1  interrupt to CPU = int_enable & synced io_interrupt
- int_enable  output  1  interrupt enable flip-flop (ION state)

Behaviour:
- Reset (async): FSM=IDLE, req_ready=1, done=0, iot=0, state=1111, mb=0, io_data_out=0, rsp_ac=0, rsp_skip=0, int_enable=0, ion_delay=0, sync regs=0, int_req=0.
- FSM states: IDLE, F0, F1, F2, F3, DONE.
- IDLE: on req_valid, latch req_inst→mb, req_ac→io_data_out and ac_hold. If req_inst[8:3]==0, go to DONE with no bus cycle (iot stays 0). Otherwise go to F0.
- F0..F3: iot=1, state=encoding. A cycle counter advances the state every STATE_CYCLES clocks, so the bus cycle is exactly 4*STATE_CYCLES clocks.
- Last clock of F3: capture skip_l=io_skip. If io_data_avail, ac_hold←io_data_in; else ac_hold unchanged. Then go to DONE.
- Peripheral values outside the last F3 clock are ignored.
- DONE (one clock): done=1, rsp_ac=ac_hold, rsp_skip=skip_l (or internal skip), iot=0, state=1111; next IDLE.
- Latency: req accepted → done = 4*STATE_CYCLES+1 clocks for a bus IOT; 1 clock for device 00.
- req_valid while not IDLE is ignored; no queuing.
- Device 00 (internal):
  - 6001 ION sets ion_delay. int_enable becomes 1 at the done of the next instruction reported via done. Standard PDP-8 one-instruction ION delay.
  - 6002 IOF clears int_enable and ion_delay immediately.
  - 6000 SKON: rsp_skip=int_enable, then clears int_enable.
  - Other device-00 codes: rsp_ac=req_ac, rsp_skip=0.
- int_req is combinational from int_enable and the synced interrupt: 2-clock latency from io_interrupt when SYNC_INT=1. int_req may assert mid-IOT; the CPU samples it only at instruction boundaries.
- rsp_ac/rsp_skip hold their values until the next done.
- Reset asserted mid-cycle aborts immediately: iot drops, no done pulse.

Test Plan:
- Reset 50 ns → req_ready=1, iot=0, state=1111, int_req=0, int_enable=0.
- Request 6603 (STATE_CYCLES=1), AC=0o1234, peripheral holds io_data_avail=0, io_skip=0 → mb=0o6603, io_select=0o60, F0..F3 one clock each, done on clock 5, rsp_ac=0o1234, rsp_skip=0.
- Request 6611 with peripheral driving io_data_avail=1, io_data_in=0o7777, io_skip=1 only in F3 → rsp_ac=0o7777, rsp_skip=1. The same values driven only in F1 → rsp_ac unchanged, rsp_skip=0.
- STATE_CYCLES=3: request 6605 → iot high exactly 12 clocks, each state held 3 clocks, done 13 clocks after accept.
- ION delay: issue 6001 → done after 1 clock with int_enable=0. Then issue 6603 → int_enable=1 at its done, and int_req rises 2 clocks after io_interrupt=1. Then 6002 → int_enable=0, int_req=0.
- Abort and busy: assert reset during F2 → iot=0 and state=1111 immediately, no done. A req_valid pulse during F1 of a fresh cycle → ignored, exactly one done.
